// File: rtl/status_checker.sv
// Checks the startup status stream (0 during startup, then 1/2 alternating) and reports
// lock, sticky error, pair count and an LED heartbeat. Define STATUS_SYNC_EN to add a 2-flop input synchronizer.
module status_checker #(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned HB_W  = 24
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       status,
   input  logic             clear,
   output logic             locked,
   output logic             error,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] pair_count,
   output logic             heartbeat
);

   typedef enum logic [2:0] {StInit, StZero, StOne, StTwo, StFail} state_e;

   state_e           state_q, state_d;
   logic [1:0]       s_q, s_d;
   logic             locked_q, locked_d;
   logic             error_q, error_d;
   logic [1:0]       code_q, code_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [HB_W-1:0]  div_q, div_d;
   logic             hb_q, hb_d;
   logic             viol;

`ifdef STATUS_SYNC_EN
   logic [1:0] sync1_q, sync2_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 2'd0;
         sync2_q <= 2'd0;
      end else begin
         sync1_q <= status;
         sync2_q <= sync1_q;
      end
   end

   assign s_d = sync2_q;
`else
   assign s_d = status;
`endif

   always_comb begin
      state_d  = state_q;
      locked_d = locked_q;
      error_d  = error_q;
      code_d   = code_q;
      cnt_d    = cnt_q;
      viol     = 1'b0;
      case (state_q)
         StInit: if (s_q == 2'd0) state_d = StZero;
         StZero: begin
            if (s_q == 2'd1) begin
               state_d  = StOne;
               locked_d = 1'b1;
            end else if (s_q != 2'd0) begin
               viol = 1'b1;
            end
         end
         StOne: begin
            if (s_q == 2'd2) begin
               state_d = StTwo;
               if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
            end else begin
               viol = 1'b1;
            end
         end
         StTwo: begin
            if (s_q == 2'd1) state_d = StOne;
            else             viol    = 1'b1;
         end
         StFail:  ;
         default: state_d = StInit;
      endcase
      if (viol) begin
         state_d  = StFail;
         locked_d = 1'b0;
         error_d  = 1'b1;
         code_d   = s_q;
      end
      // Clear overrides any violation seen in the same cycle.
      if (clear) begin
         state_d  = StInit;
         locked_d = 1'b0;
         error_d  = 1'b0;
         code_d   = 2'd0;
         cnt_d    = '0;
      end
   end

   always_comb begin
      div_d = div_q + HB_W'(1);
      if (state_q == StFail) hb_d = 1'b1;
      else if (locked_q)     hb_d = div_q[HB_W-1];
      else                   hb_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StInit;
         s_q      <= 2'd0;
         locked_q <= 1'b0;
         error_q  <= 1'b0;
         code_q   <= 2'd0;
         cnt_q    <= '0;
         div_q    <= '0;
         hb_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         s_q      <= s_d;
         locked_q <= locked_d;
         error_q  <= error_d;
         code_q   <= code_d;
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         hb_q     <= hb_d;
      end
   end

   assign locked     = locked_q;
   assign error      = error_q;
   assign err_code   = code_q;
   assign pair_count = cnt_q;
   assign heartbeat  = hb_q;

endmodule

// File: tb/tb_status_checker.sv
// Randomized scoreboard bench for status_checker with CNT_W=4, HB_W=4; follows STATUS_SYNC_EN
// for the expected input latency.
module tb_status_checker;

   localparam int unsigned CNT_W = 4;
   localparam int unsigned HB_W  = 4;
`ifdef STATUS_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic             clk = 1'b0;
   logic             reset_n = 1'b1;
   logic [1:0]       status = 2'd0;
   logic             clear = 1'b0;
   logic             locked, error, heartbeat;
   logic [1:0]       err_code;
   logic [CNT_W-1:0] pair_count;

   status_checker #(.CNT_W(CNT_W), .HB_W(HB_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .status     (status),
      .clear      (clear),
      .locked     (locked),
      .error      (error),
      .err_code   (err_code),
      .pair_count (pair_count),
      .heartbeat  (heartbeat)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       lk;
      logic       er;
      logic [1:0] code;
      logic [3:0] cnt;
      logic       hb;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;

   // Reference model: pattern rules in terms of "armed / locked / next wanted value".
   int   pipe[$];
   bit   m_armed, m_locked, m_failed;
   int   m_want, m_code, m_cnt, m_div, m_hb;

   function automatic void model_reset();
      pipe.delete();
      for (int i = 0; i < LAT; i++) pipe.push_back(0);
      m_armed = 0; m_locked = 0; m_failed = 0;
      m_want = 1; m_code = 0; m_cnt = 0; m_div = 0; m_hb = 0;
   endfunction

   function automatic void model_tick(input int st, input bit clr);
      int   s;
      exp_t e;
      s = pipe[0];
      m_hb  = m_failed ? 1 : (m_locked ? ((m_div >> (HB_W - 1)) & 1) : 0);
      m_div = (m_div + 1) % (1 << HB_W);
      if (clr) begin
         m_armed = 0; m_locked = 0; m_failed = 0; m_code = 0; m_cnt = 0;
      end else if (m_failed) begin
      end else if (!m_armed) begin
         if (s == 0) m_armed = 1;
      end else if (!m_locked) begin
         if (s == 1) begin
            m_locked = 1; m_want = 2;
         end else if (s != 0) begin
            m_failed = 1; m_code = s;
         end
      end else if (s == m_want) begin
         if (m_want == 2 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
         m_want = 3 - m_want;
      end else begin
         m_failed = 1; m_locked = 0; m_code = s;
      end
      void'(pipe.pop_front());
      pipe.push_back(st);
      e.lk = m_locked; e.er = m_failed; e.code = 2'(m_code);
      e.cnt = 4'(m_cnt); e.hb = m_hb[0];
      exp_q.push_back(e);
   endfunction

   task automatic step(input int st, input bit clr);
      @(negedge clk);
      status = 2'(st);
      clear  = clr;
      model_tick(st, clr);
      @(posedge clk);
   endtask

   task automatic do_reset(input string name);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({locked, error, err_code, pair_count, heartbeat} != '0) begin
         failures++;
         $display("FAIL %s: got lk=%0b er=%0b code=%0d cnt=%0d hb=%0b, want all 0", name,
                  locked, error, err_code, pair_count, heartbeat);
      end
      model_reset();
      @(posedge clk);
      #2 reset_n = 1'b1;
   endtask

   task automatic nominal();
      int seq[8] = '{0, 0, 1, 2, 1, 2, 1, 2};
      foreach (seq[i]) step(seq[i], 1'b0);
      for (int i = 0; i < LAT + 2; i++) step((i % 2 == 0) ? 1 : 2, 1'b0);
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         checks++;
         if (locked !== mon_e.lk || error !== mon_e.er || err_code !== mon_e.code ||
             pair_count !== mon_e.cnt || heartbeat !== mon_e.hb) begin
            failures++;
            $display("FAIL outputs t=%0t: got lk=%0b er=%0b code=%0d cnt=%0d hb=%0b, want lk=%0b er=%0b code=%0d cnt=%0d hb=%0b",
                     $time, locked, error, err_code, pair_count, heartbeat,
                     mon_e.lk, mon_e.er, mon_e.code, mon_e.cnt, mon_e.hb);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, z, v;
      bit c;
      model_reset();
      do_reset("reset_values");

      nominal();

      // early violation
      step(0, 1'b1);
      step(0, 1'b0);
      for (int i = 0; i < LAT + 3; i++) step(2, 1'b0);

      // violation while locked
      step(0, 1'b1);
      begin
         int seq[5] = '{0, 1, 2, 1, 3};
         foreach (seq[i]) step(seq[i], 1'b0);
      end
      for (int i = 0; i < LAT + 3; i++) step(3, 1'b0);

      // clear arrives on the cycle the bad value sits in s_q
      step(0, 1'b1);
      step(0, 1'b0);
      step(1, 1'b0);
      step(2, 1'b0);
      for (int i = 0; i < LAT; i++) step(3, 1'b0);
      step(3, 1'b1);
      for (int i = 0; i < 4; i++) step(3, 1'b0);

      // saturation and heartbeat period
      step(0, 1'b1);
      step(0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         step(1, 1'b0);
         step(2, 1'b0);
      end

      // randomized pattern with occasional corruption and clears
      k = 0;
      z = 2;
      for (int i = 0; i < 400; i++) begin
         c = ($urandom_range(39) == 0);
         if (c) begin
            k = 0;
            z = int'($urandom_range(3, 1));
         end
         v = (k < z) ? 0 : (((k - z) % 2 == 0) ? 1 : 2);
         if ($urandom_range(24) == 0) v = int'($urandom_range(3));
         k++;
         step(v, c);
      end

      // async reset mid-pattern, then lock again
      step(0, 1'b1);
      step(0, 1'b0);
      step(1, 1'b0);
      step(2, 1'b0);
      step(1, 1'b0);
      do_reset("async_reset");
      nominal();

      repeat (2) @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
